// File: rtl/demuxn_deser_if.sv
// demuxn_deser_if -- handshake/data bundle for the serial-to-parallel demux.
//
// Signals:
//   clear      : synchronous abort of the partially assembled word
//   in_bit     : serial data bit
//   in_valid   : in_bit is valid this cycle
//   in_ready   : deserializer accepts in_bit this cycle
//   sel        : destination index of the next accepted bit
//   out_data   : last completed word
//   out_valid  : out_data holds an unconsumed word
//   out_ready  : consumer takes out_data this cycle
//
// Modports:
//   master : the side that feeds bits and consumes words (e.g. a testbench)
//   slave  : the deserializer itself
interface demuxn_deser_if #(
  parameter int OWIDTH = 20,
  parameter int SWIDTH = 5
);
  logic              clear;
  logic              in_bit;
  logic              in_valid;
  logic              in_ready;
  logic [SWIDTH-1:0] sel;
  logic [OWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output clear, in_bit, in_valid, out_ready,
    input  in_ready, sel, out_data, out_valid
  );

  modport slave (
    input  clear, in_bit, in_valid, out_ready,
    output in_ready, sel, out_data, out_valid
  );
endinterface

// File: rtl/demuxn_deser.sv
// demuxn_deser -- serial-to-parallel deserializer built as a 1-to-OWIDTH
// bit demux. Each accepted bit is routed to assembly[sel], LSB first; when
// the last position is written the whole word moves to out_data and the
// block stalls (FULL) until the consumer takes it.
//
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   rst   : synchronous, active-high reset (priority over everything)
//   bus   : demuxn_deser_if.slave -- clear, in_bit/in_valid/in_ready,
//           sel, out_data/out_valid/out_ready
//
// Parameters:
//   OWIDTH : word width / number of demux destinations
//   SWIDTH : index width, must satisfy OWIDTH <= 2**SWIDTH
module demuxn_deser #(
  parameter int OWIDTH = 20,
  parameter int SWIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  demuxn_deser_if.slave   bus
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [SWIDTH-1:0] LAST_SEL = SWIDTH'(OWIDTH - 1);

  state_t            state_q, state_d;
  logic [SWIDTH-1:0] sel_q, sel_d;
  logic [OWIDTH-1:0] asm_q, asm_d;
  logic [OWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  logic in_ready_w;
  logic accept_w;
  logic out_ev_w;

  // In FULL a new bit may only enter when the pending word leaves in the
  // same cycle, so the assembly never overruns an unconsumed word.
  assign in_ready_w = !rst && !bus.clear &&
                      ((state_q == FILL) || bus.out_ready);
  assign accept_w   = bus.in_valid && in_ready_w;
  assign out_ev_w   = valid_q && bus.out_ready;

  // One write enable per destination: the demux proper. asm_d already
  // contains the bit being accepted, so it is the completed word when
  // sel hits the last position.
  generate
    for (genvar gi = 0; gi < OWIDTH; gi++) begin : g_route
      assign asm_d[gi] = (accept_w && (sel_q == SWIDTH'(gi))) ? bus.in_bit
                                                              : asm_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;

    // Consumption always releases FULL; an accept below may re-enter it
    // only if the word is a single bit wide.
    if (out_ev_w) begin
      valid_d = 1'b0;
      state_d = FILL;
    end

    if (bus.clear) begin
      // Rewinding sel is enough to discard the partial word: every
      // position is overwritten before the next word completes.
      sel_d = '0;
    end else if (accept_w) begin
      if (sel_q == LAST_SEL) begin
        data_d  = asm_d;
        valid_d = 1'b1;
        sel_d   = '0;
        state_d = FULL;
      end else begin
        sel_d = sel_q + SWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      sel_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_demuxn_deser.sv
// tb_demuxn_deser -- scoreboard bench for demuxn_deser.
// A reference model (bit queue + pending-word flag) predicts handshake and
// status outputs every cycle and pushes each completed word into a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT presents a consumed word.
module tb_demuxn_deser;
  localparam int OW = 20;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  demuxn_deser_if #(.OWIDTH(OW), .SWIDTH(SW)) bus ();

  demuxn_deser #(.OWIDTH(OW), .SWIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [OW-1:0] sb_q[$];   // expected words, in completion order
  bit            pend[$];   // bits accepted so far in the current word
  bit            full_m = 1'b0;
  logic [OW-1:0] last_m = '0;

  // ---------------- reference model ----------------
  always @(negedge clk) begin
    logic          exp_rdy;
    logic [OW-1:0] word;
    exp_rdy = !rst && !bus.clear && (!full_m || bus.out_ready);
    tests++;
    if (bus.in_ready !== exp_rdy || bus.sel !== SW'(pend.size()) ||
        bus.out_valid !== full_m || bus.out_data !== last_m) begin
      fails++;
      $display("FAIL cycle_state t=%0t got rdy=%b sel=%0d vld=%b data=%h want rdy=%b sel=%0d vld=%b data=%h",
               $time, bus.in_ready, bus.sel, bus.out_valid, bus.out_data,
               exp_rdy, pend.size(), full_m, last_m);
    end
    if (rst) begin
      pend.delete();
      sb_q.delete();
      full_m = 1'b0;
      last_m = '0;
    end else begin
      if (full_m && bus.out_ready) full_m = 1'b0;
      if (bus.clear) begin
        pend.delete();
      end else if (bus.in_valid && exp_rdy) begin
        pend.push_back(bus.in_bit);
        if (pend.size() == OW) begin
          word = '0;
          for (int i = 0; i < OW; i++) word[i] = pend[i];
          sb_q.push_back(word);
          last_m = word;
          full_m = 1'b1;
          pend.delete();
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [OW-1:0] exp_w;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL word_unexpected t=%0t got %h required none", $time, bus.out_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (bus.out_data !== exp_w) begin
          fails++;
          $display("FAIL word t=%0t got %h required %h", $time, bus.out_data, exp_w);
        end else begin
          $display("[TB] word t=%0t data=%h ok", $time, bus.out_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    logic acc;
    int   k;
    k = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      k++;
    end while (!acc && k < 200);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout t=%0t got no in_ready required in_ready within 200 cycles", $time);
    end
  endtask

  task automatic send_bits(input logic [OW-1:0] w, input int n);
    logic [OW-1:0] wv;
    wv = w;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = wv[i];
      wait_accept();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // basic word, consumer stalled
    send_bits(20'hF57CE, OW);
    bus.in_valid = 1'b1;
    repeat (2) step();
    bus.in_valid = 1'b0;
    drain();

    // per-index routing
    bus.out_ready = 1'b1;
    for (int i = 0; i < OW; i++) send_bits(OW'(1) << i, OW);
    repeat (2) step();

    // back-to-back streaming
    send_bits(20'hF57CE, OW);
    send_bits(20'h0A5A5, OW);
    repeat (2) step();

    // backpressure
    bus.out_ready = 1'b0;
    send_bits(20'h3C3C3, OW);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    repeat (5) step();
    bus.out_ready = 1'b1;
    send_bits(20'hABCDE, OW);
    repeat (2) step();

    // clear mid-word
    send_bits(20'hFFFFF, 7);
    bus.clear = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    send_bits(20'h12345, OW);
    repeat (2) step();

    // reset mid-word and in FULL
    send_bits(20'hFFFFF, 11);
    pulse_rst();
    step();
    bus.out_ready = 1'b0;
    send_bits(20'h55AA5, OW);
    step();
    pulse_rst();
    step();
    send_bits(20'h6789A, OW);
    drain();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_bit    = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.clear     = ($urandom_range(0, 40) == 0);
      rst           = ($urandom_range(0, 300) == 0);
      step();
    end
    rst          = 1'b0;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    drain();
    repeat (2) step();

    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty got %0d pending words required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
